// File: rtl/codeword_serializer.sv
// codeword_serializer
// Accepts one N-bit codeword per valid/ready handshake, XORs in an error mask
// at load, and shifts the result onto a 1-bit channel MSB first. SOF marks the
// first bit and EOF the last. Downstream stall freezes the current bit.
// Back-to-back frames are accepted on the EOF edge, so a continuous input
// stream leaves the channel with no bubble between frames. A wrapping 16-bit
// counter records completed frames.
module codeword_serializer #(
  parameter int N     = 64,
  parameter int CNT_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] data_in,
  input  logic [N-1:0] err_mask,
  input  logic         ser_stall,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         ser_sof,
  output logic         ser_eof,
  output logic         busy,
  output logic [15:0]  frame_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Index of the first (most significant) bit of a frame.
  localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(N - 1);

  state_t           state;
  state_t           state_nxt;
  logic [N-1:0]     shreg;
  logic [CNT_W-1:0] idx;

  logic             in_shift;
  logic             last;
  logic             advance;
  logic             load;

  // Handshake and frame-position qualifiers shared by all processes.
  always_comb begin
    in_shift = (state == SHIFT);
    last     = in_shift && (idx == '0);
    advance  = in_shift && !ser_stall;
    in_ready = (state == IDLE) || (last && !ser_stall);
    load     = in_valid && in_ready;
  end

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: leave IDLE on load, leave SHIFT after the last bit unless a
  // new codeword is accepted on that same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (advance && last) state_nxt = load ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Codeword capture (with error mask applied) and bit-index countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= data_in ^ err_mask;
      idx   <= IDX_TOP;
    end else if (advance && !last) begin
      idx <= idx - CNT_W'(1);
    end
  end

  // Completed-frame counter, bumped when the EOF bit is actually taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (advance && last) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Channel outputs: driven from the held register state only, so a stalled
  // cycle repeats exactly the same bit and flags.
  always_comb begin
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    ser_sof   = 1'b0;
    ser_eof   = 1'b0;
    busy      = 1'b0;
    if (in_shift) begin
      ser_out   = shreg[idx];
      ser_valid = 1'b1;
      ser_sof   = (idx == IDX_TOP);
      ser_eof   = (idx == '0);
      busy      = 1'b1;
    end
  end

endmodule
